// File: rtl/ysyx_220066_fetch_buf_pkg.sv
// Shared definitions for the fetch buffer: FSM state encoding, reset PC,
// instruction width and the aligned-word lane select.
package ysyx_220066_fetch_buf_pkg;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int unsigned INST_W   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrop
    } fetch_state_e;

    // The bus returns an 8-byte aligned doubleword; pc[2] picks the 32-bit lane.
    function automatic logic [INST_W-1:0] select_word(input logic [63:0] data,
                                                      input logic        upper);
        return upper ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ysyx_220066_fetch_fifo.sv
// Small circular queue of fetched {pc, inst, misalign} entries.
//  clk, rst   : clock, synchronous active-high reset
//  clear      : drop every entry next cycle; push/pop in the same cycle are ignored
//  push/wdata : write an entry (never issued while full)
//  pop        : consume the head (only while valid)
//  rdata      : head entry, valid while the queue is non-empty
//  valid/full : occupancy flags
module ysyx_220066_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 97
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/ysyx_220066_fetch_buf.sv
// Fetch stage between the PC generator and ID. Captures the PC, issues one
// instruction-memory read at a time, selects the 32-bit word and queues
// {pc, inst, misalign} for ID. A redirect (flush_i) discards in-flight work.
//  clk, rst              : clock, synchronous active-high reset
//  pc_i, flush_i         : current PC and redirect from the PC generator
//  block_o               : hold the PC generator; low exactly when pc_i is captured
//                          or a redirect is in progress
//  imem_req_*            : read request channel (valid/ready, registered address)
//  imem_resp_*           : read response, one pulse per accepted request
//  id_valid/id_ready     : queue head handshake toward ID
//  id_pc/id_inst/id_misalign : head entry contents
module ysyx_220066_fetch_buf
    import ysyx_220066_fetch_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              flush_i,
    output logic              block_o,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [XLEN-1:0]   imem_resp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_misalign
);

    localparam int unsigned ENTRY_W = XLEN + INST_W + 1;

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    addr_q;
    logic               drop_q;
    logic               drop_d;
    logic               issue;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_out;
    logic [INST_W-1:0]  inst_sel;

    // A queue slot is reserved at issue time, so the later push can never overflow.
    assign issue = !rst && (state_q == StIdle) && !flush_i && !fifo_full;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // The request stays up once raised; a redirect only marks it stale.
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (imem_req_ready) begin
                    state_d = (drop_q || flush_i) ? StDrop : StWait;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    push    = !flush_i;
                    state_d = StIdle;
                end else if (flush_i) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_resp_valid) begin
                    state_d = StIdle;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            drop_q  <= 1'b0;
            pc_q    <= XLEN'(RESET_PC);
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (issue) begin
                pc_q   <= pc_i;
                addr_q <= {pc_i[XLEN-1:3], 3'b000};
            end
        end
    end

    assign block_o        = !(issue || flush_i);
    assign imem_req_valid = (state_q == StReq);
    assign imem_req_addr  = addr_q;

    // Misaligned PCs are still fetched; ID decides what to do with the flag.
    assign inst_sel = select_word(imem_resp_data, pc_q[2]);
    assign entry_in = {pc_q, inst_sel, (pc_q[1:0] != 2'b00)};

    assign pop = id_valid && id_ready;

    ysyx_220066_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_i),
        .push  (push),
        .wdata (entry_in),
        .pop   (pop),
        .rdata (entry_out),
        .valid (id_valid),
        .full  (fifo_full)
    );

    assign id_pc       = entry_out[ENTRY_W-1 -: XLEN];
    assign id_inst     = entry_out[INST_W:1];
    assign id_misalign = entry_out[0];

endmodule
